// File: rtl/motion_diff_stream_if.sv
// Streaming bundle for motion_diff_stream: configuration, pixel input beats
// and the per-pixel / per-frame result signals.
// The master side is the pixel source; the slave side is the detector.
interface motion_diff_stream_if #(
    parameter int CW    = 8,
    parameter int NCH   = 3,
    parameter int CNT_W = 20
);
    logic [CW+1:0]     cfg_threshold;
    logic [CNT_W-1:0]  cfg_min_pixels;
    logic              in_valid;
    logic              in_sof;
    logic              in_eof;
    logic [NCH*CW-1:0] in_cur;
    logic [NCH*CW-1:0] in_prev;
    logic              pix_valid;
    logic              pix_sof;
    logic              pix_eof;
    logic              pix_motion;
    logic              frame_done;
    logic [CNT_W-1:0]  frame_count;
    logic              frame_motion;

    modport master (
        output cfg_threshold, cfg_min_pixels,
        output in_valid, in_sof, in_eof, in_cur, in_prev,
        input  pix_valid, pix_sof, pix_eof, pix_motion,
        input  frame_done, frame_count, frame_motion
    );

    modport slave (
        input  cfg_threshold, cfg_min_pixels,
        input  in_valid, in_sof, in_eof, in_cur, in_prev,
        output pix_valid, pix_sof, pix_eof, pix_motion,
        output frame_done, frame_count, frame_motion
    );
endinterface

// File: rtl/motion_diff_stream.sv
// motion_diff_stream: streaming per-pixel frame-difference detector.
// Stage 1 registers |cur-prev| per channel and latches the frame
// configuration on SOF; stage 2 makes the per-pixel decision (ANY or SUM);
// the frame tracker counts motion pixels and reports a verdict one cycle
// after the EOF pixel leaves stage 2.
//
// Frame tracker states:
//   state     | meaning
//   ST_IDLE   | between frames; pixels are flagged but not counted
//   ST_ACTIVE | inside a frame; motion pixels accumulate in cnt_q
module motion_diff_stream #(
    parameter int CW    = 8,
    parameter int NCH   = 3,
    parameter int CNT_W = 20,
    parameter int MODE  = 0
) (
    input  logic                clk,
    input  logic                reset,
    motion_diff_stream_if.slave bus
);
    localparam int TW = CW + 2;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // stage 1
    logic                    s1_valid_d, s1_valid_q;
    logic                    s1_sof_d, s1_sof_q;
    logic                    s1_eof_d, s1_eof_q;
    logic [NCH-1:0][CW-1:0]  diff_d, diff_q;
    logic [TW-1:0]           thr_d, thr_q;
    logic [CNT_W-1:0]        min_d, min_q;

    // stage 2
    logic                    pix_valid_d, pix_valid_q;
    logic                    pix_sof_d, pix_sof_q;
    logic                    pix_eof_d, pix_eof_q;
    logic                    pix_motion_d, pix_motion_q;
    logic [CNT_W-1:0]        frm_min_d, frm_min_q;
    logic                    any_hit;
    logic [TW-1:0]           diff_sum;

    // frame tracker
    state_t                  state_d, state_q;
    logic [CNT_W-1:0]        cnt_d, cnt_q;
    logic [CNT_W-1:0]        cnt_inc;
    logic                    done_d, done_q;
    logic [CNT_W-1:0]        fcount_d, fcount_q;
    logic                    fmotion_d, fmotion_q;

    // Stage 1: absolute channel differences, qualified sidebands, cfg capture on SOF
    always_comb begin
        s1_valid_d = bus.in_valid;
        s1_sof_d   = bus.in_valid & bus.in_sof;
        s1_eof_d   = bus.in_valid & bus.in_eof;
        thr_d      = thr_q;
        min_d      = min_q;
        diff_d     = '0;
        if (s1_sof_d) begin
            thr_d = bus.cfg_threshold;
            min_d = bus.cfg_min_pixels;
        end
        for (int c = 0; c < NCH; c++) begin
            if (bus.in_cur[c*CW +: CW] >= bus.in_prev[c*CW +: CW])
                diff_d[c] = bus.in_cur[c*CW +: CW] - bus.in_prev[c*CW +: CW];
            else
                diff_d[c] = bus.in_prev[c*CW +: CW] - bus.in_cur[c*CW +: CW];
        end
    end

    // Stage 2: per-pixel decision; min_pixels follows the SOF pixel so a
    // back-to-back SOF cannot overwrite it before the previous frame closes
    always_comb begin
        any_hit  = 1'b0;
        diff_sum = '0;
        for (int c = 0; c < NCH; c++) begin
            if (diff_q[c] > thr_q[CW-1:0])
                any_hit = 1'b1;
            diff_sum = diff_sum + {2'b00, diff_q[c]};
        end
        pix_valid_d  = s1_valid_q;
        pix_sof_d    = s1_sof_q;
        pix_eof_d    = s1_eof_q;
        pix_motion_d = s1_valid_q & ((MODE == 1) ? (diff_sum > thr_q) : any_hit);
        frm_min_d    = s1_sof_q ? min_q : frm_min_q;
    end

    // Frame tracker: next state, saturating count and end-of-frame verdict
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        fcount_d  = fcount_q;
        fmotion_d = fmotion_q;
        cnt_inc   = (cnt_q == '1) ? cnt_q
                                  : cnt_q + {{(CNT_W-1){1'b0}}, pix_motion_q};
        if (pix_sof_q) begin
            // a SOF while ACTIVE simply discards the unfinished count
            cnt_d   = {{(CNT_W-1){1'b0}}, pix_motion_q};
            state_d = ST_ACTIVE;
        end else if (state_q == ST_ACTIVE && pix_valid_q) begin
            cnt_d = cnt_inc;
        end
        if (pix_eof_q && (pix_sof_q || state_q == ST_ACTIVE)) begin
            done_d    = 1'b1;
            fcount_d  = cnt_d;
            fmotion_d = (cnt_d >= frm_min_q);
            state_d   = ST_IDLE;
        end
    end

    // Frame tracker state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Pipeline and result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q   <= 1'b0;
            s1_sof_q     <= 1'b0;
            s1_eof_q     <= 1'b0;
            diff_q       <= '0;
            thr_q        <= '0;
            min_q        <= '0;
            pix_valid_q  <= 1'b0;
            pix_sof_q    <= 1'b0;
            pix_eof_q    <= 1'b0;
            pix_motion_q <= 1'b0;
            frm_min_q    <= '0;
            cnt_q        <= '0;
            done_q       <= 1'b0;
            fcount_q     <= '0;
            fmotion_q    <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_sof_q     <= s1_sof_d;
            s1_eof_q     <= s1_eof_d;
            diff_q       <= diff_d;
            thr_q        <= thr_d;
            min_q        <= min_d;
            pix_valid_q  <= pix_valid_d;
            pix_sof_q    <= pix_sof_d;
            pix_eof_q    <= pix_eof_d;
            pix_motion_q <= pix_motion_d;
            frm_min_q    <= frm_min_d;
            cnt_q        <= cnt_d;
            done_q       <= done_d;
            fcount_q     <= fcount_d;
            fmotion_q    <= fmotion_d;
        end
    end

    assign bus.pix_valid    = pix_valid_q;
    assign bus.pix_sof      = pix_sof_q;
    assign bus.pix_eof      = pix_eof_q;
    assign bus.pix_motion   = pix_motion_q;
    assign bus.frame_done   = done_q;
    assign bus.frame_count  = fcount_q;
    assign bus.frame_motion = fmotion_q;
endmodule

// File: tb/tb_motion_diff_stream.sv
// Directed bench for motion_diff_stream: three instances (ANY, SUM, and a
// 4-bit counter ANY) share one stimulus stream; expected values are hand-derived.
module tb_motion_diff_stream;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        v = 1'b0, s = 1'b0, e = 1'b0;
    logic [23:0] cur = '0, prev = '0;
    logic [9:0]  thr = '0;
    logic [19:0] minp = '0;
    int          checks = 0;
    int          failures = 0;
    int          done_any = 0, done_sat = 0;
    int          dc, ds;

    always #5 clk = ~clk;

    motion_diff_stream_if #(.CW(8), .NCH(3), .CNT_W(20)) if_any ();
    motion_diff_stream_if #(.CW(8), .NCH(3), .CNT_W(20)) if_sum ();
    motion_diff_stream_if #(.CW(8), .NCH(3), .CNT_W(4))  if_sat ();

    assign if_any.cfg_threshold = thr;  assign if_any.cfg_min_pixels = minp;
    assign if_any.in_valid = v; assign if_any.in_sof = s; assign if_any.in_eof = e;
    assign if_any.in_cur = cur; assign if_any.in_prev = prev;
    assign if_sum.cfg_threshold = thr;  assign if_sum.cfg_min_pixels = minp;
    assign if_sum.in_valid = v; assign if_sum.in_sof = s; assign if_sum.in_eof = e;
    assign if_sum.in_cur = cur; assign if_sum.in_prev = prev;
    assign if_sat.cfg_threshold = thr;  assign if_sat.cfg_min_pixels = minp[3:0];
    assign if_sat.in_valid = v; assign if_sat.in_sof = s; assign if_sat.in_eof = e;
    assign if_sat.in_cur = cur; assign if_sat.in_prev = prev;

    motion_diff_stream #(.CW(8), .NCH(3), .CNT_W(20), .MODE(0)) dut_any (
        .clk(clk), .reset(reset), .bus(if_any.slave));
    motion_diff_stream #(.CW(8), .NCH(3), .CNT_W(20), .MODE(1)) dut_sum (
        .clk(clk), .reset(reset), .bus(if_sum.slave));
    motion_diff_stream #(.CW(8), .NCH(3), .CNT_W(4), .MODE(0)) dut_sat (
        .clk(clk), .reset(reset), .bus(if_sat.slave));

    // count frame_done pulses away from the active edge
    always @(negedge clk) begin
        if (if_any.frame_done) done_any++;
        if (if_sat.frame_done) done_sat++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic beat(input logic bv, input logic bs, input logic be,
                        input logic [23:0] bc, input logic [23:0] bp);
        v = bv; s = bs; e = be; cur = bc; prev = bp;
        @(posedge clk); #1;
    endtask

    // motion pixel: ch0 diff 100; still pixel: diff 0
    task automatic px(input logic bs, input logic be, input logic mot);
        beat(1'b1, bs, be, mot ? 24'd100 : 24'd50, mot ? 24'd0 : 24'd50);
    endtask

    task automatic idle(input int n);
        v = 1'b0; s = 1'b0; e = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pix_valid", 32'(if_any.pix_valid), 32'd0);
        chk("rst_pix_motion", 32'(if_any.pix_motion), 32'd0);
        chk("rst_frame_done", 32'(if_any.frame_done), 32'd0);
        chk("rst_frame_count", 32'(if_any.frame_count), 32'd0);
        chk("rst_frame_motion", 32'(if_any.frame_motion), 32'd0);
        #2 reset = 1'b0;
        @(posedge clk); #1;

        // 1: ANY, thr=20, diff 21 vs diff 20 (strict >)
        thr = 10'd20; minp = 20'd0;
        beat(1'b1, 1'b1, 1'b1, 24'd30, 24'd9);
        beat(1'b1, 1'b0, 1'b0, 24'd30, 24'd10);
        chk("t1_motion_21", 32'(if_any.pix_motion), 32'd1);
        chk("t1_pix_sof", 32'(if_any.pix_sof), 32'd1);
        chk("t1_pix_eof", 32'(if_any.pix_eof), 32'd1);
        idle(1);
        chk("t1_motion_20", 32'(if_any.pix_motion), 32'd0);
        chk("t1_pix_sof_b2", 32'(if_any.pix_sof), 32'd0);
        chk("t1_done_1px", 32'(if_any.frame_done), 32'd1);
        chk("t1_count_1px", 32'(if_any.frame_count), 32'd1);
        chk("t1_min0_motion", 32'(if_any.frame_motion), 32'd1);
        idle(1);
        chk("t1_done_pulse", 32'(if_any.frame_done), 32'd0);
        chk("t1_idle_valid", 32'(if_any.pix_valid), 32'd0);
        chk("t1_idle_motion", 32'(if_any.pix_motion), 32'd0);
        idle(2);

        // 2: SUM, thr=40: sum 45 -> 1, sum 40 -> 0
        thr = 10'd40;
        beat(1'b1, 1'b1, 1'b0, 24'h0F0F0F, 24'd0);
        beat(1'b1, 1'b0, 1'b1, 24'h0F0F0A, 24'd0);
        chk("t2_sum45", 32'(if_sum.pix_motion), 32'd1);
        chk("t2_any_15", 32'(if_any.pix_motion), 32'd0);
        idle(1);
        chk("t2_sum40", 32'(if_sum.pix_motion), 32'd0);
        idle(1);
        chk("t2_sum_done", 32'(if_sum.frame_done), 32'd1);
        chk("t2_sum_count", 32'(if_sum.frame_count), 32'd1);
        idle(2);

        // 3: 16-pixel frame, motion at 0,3,7,11,15; min=5 then min=6
        thr = 10'd20;
        for (int m = 5; m <= 6; m++) begin
            minp = 20'(m);
            for (int i = 0; i < 16; i++)
                px(i == 0, i == 15, (i % 4 == 3) || i == 0);
            idle(1);
            chk("t3_done_early", 32'(if_any.frame_done), 32'd0);
            idle(1);
            chk("t3_done", 32'(if_any.frame_done), 32'd1);
            chk("t3_count", 32'(if_any.frame_count), 32'd5);
            chk("t3_motion", 32'(if_any.frame_motion), (m == 5) ? 32'd1 : 32'd0);
            idle(2);
        end
        chk("t3_count_held", 32'(if_any.frame_count), 32'd5);

        // 4: thr 20 -> 200 mid-frame; next frame uses 200
        thr = 10'd20; minp = 20'd0;
        px(1'b1, 1'b0, 1'b1);
        thr = 10'd200;
        px(1'b0, 1'b0, 1'b1);
        px(1'b0, 1'b0, 1'b1);
        px(1'b0, 1'b1, 1'b1);
        idle(2);
        chk("t4_old_thr_count", 32'(if_any.frame_count), 32'd4);
        px(1'b1, 1'b0, 1'b1);
        px(1'b0, 1'b0, 1'b1);
        px(1'b0, 1'b0, 1'b1);
        px(1'b0, 1'b1, 1'b1);
        idle(2);
        chk("t4_new_thr_count", 32'(if_any.frame_count), 32'd0);
        chk("t4_min0_motion", 32'(if_any.frame_motion), 32'd1);
        idle(2);

        // 5: SOF at pixel 8 without EOF abandons first frame
        thr = 10'd20; minp = 20'd3;
        dc = done_any;
        for (int i = 0; i < 8; i++) px(i == 0, 1'b0, 1'b1);
        px(1'b1, 1'b0, 1'b1);
        px(1'b0, 1'b0, 1'b0);
        px(1'b0, 1'b0, 1'b1);
        px(1'b0, 1'b0, 1'b0);
        px(1'b0, 1'b1, 1'b1);
        idle(2);
        chk("t5_count", 32'(if_any.frame_count), 32'd3);
        chk("t5_motion_eq_min", 32'(if_any.frame_motion), 32'd1);
        idle(2);
        chk("t5_one_done", 32'(done_any - dc), 32'd1);

        // 6: 4-bit counter saturates at 15
        minp = 20'd15;
        for (int i = 0; i < 20; i++) px(i == 0, i == 19, 1'b1);
        idle(2);
        chk("t6_sat_count", 32'(if_sat.frame_count), 32'd15);
        chk("t6_sat_motion", 32'(if_sat.frame_motion), 32'd1);
        chk("t6_wide_count", 32'(if_any.frame_count), 32'd20);
        idle(2);

        // 6b: asynchronous reset mid-frame
        ds = done_sat;
        px(1'b1, 1'b0, 1'b1);
        px(1'b0, 1'b0, 1'b1);
        px(1'b0, 1'b0, 1'b1);
        reset = 1'b1;
        #1;
        chk("t6_rst_count", 32'(if_sat.frame_count), 32'd0);
        chk("t6_rst_fmotion", 32'(if_sat.frame_motion), 32'd0);
        chk("t6_rst_valid", 32'(if_sat.pix_valid), 32'd0);
        chk("t6_rst_pmotion", 32'(if_sat.pix_motion), 32'd0);
        #2 reset = 1'b0;
        @(posedge clk); #1;
        px(1'b0, 1'b0, 1'b1);
        px(1'b0, 1'b1, 1'b1);
        idle(3);
        chk("t6_no_done", 32'(done_sat - ds), 32'd0);
        chk("t6_count_after", 32'(if_sat.frame_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
